// File: rtl/hwpe_ctrl_periph2reqrsp.sv
// Bridges a periph-style request/grant port onto a reqrsp request/response pair.
// Response IDs are replayed in request order from a small FIFO sized by MAX_OUTSTANDING.
module hwpe_ctrl_periph2reqrsp #(
  parameter int unsigned AW              = 32,
  parameter int unsigned DW              = 32,
  parameter int unsigned ID_WIDTH        = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  // periph side
  input  logic                periph_req_i,
  output logic                periph_gnt_o,
  input  logic [AW-1:0]       periph_add_i,
  input  logic                periph_wen_i,
  input  logic [DW/8-1:0]     periph_be_i,
  input  logic [DW-1:0]       periph_data_i,
  input  logic [ID_WIDTH-1:0] periph_id_i,
  output logic [DW-1:0]       periph_r_data_o,
  output logic                periph_r_valid_o,
  output logic [ID_WIDTH-1:0] periph_r_id_o,
  // reqrsp side
  output logic [AW-1:0]       q_addr_o,
  output logic                q_write_o,
  output logic [DW/8-1:0]     q_strb_o,
  output logic [DW-1:0]       q_data_o,
  output logic                q_valid_o,
  input  logic                q_ready_i,
  input  logic [DW-1:0]       p_data_i,
  input  logic                p_valid_i,
  output logic                p_ready_o,
  output logic                busy_o
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MAX_OUTSTANDING);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MAX_OUTSTANDING - 1);

  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [ID_WIDTH-1:0] id_mem_q [MAX_OUTSTANDING];

  logic                r_valid_q, r_valid_d;
  logic [DW-1:0]       r_data_q, r_data_d;
  logic [ID_WIDTH-1:0] r_id_q, r_id_d;

  logic push, pop, full;

  // Request path is purely combinational; only the outstanding limit gates it.
  always_comb begin
    full         = (cnt_q >= MaxCnt);
    q_valid_o    = periph_req_i && !full;
    periph_gnt_o = q_valid_o && q_ready_i;
    q_addr_o     = periph_add_i;
    q_strb_o     = periph_be_i;
    q_data_o     = periph_data_i;
    q_write_o    = ~periph_wen_i;
    p_ready_o    = (cnt_q != '0);
    busy_o       = (cnt_q != '0);
    push         = periph_gnt_o;
    pop          = p_valid_i && p_ready_o;
  end

  always_comb begin
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear_i) begin
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + CntW'(1);
        2'b01:   cnt_d = cnt_q - CntW'(1);
        default: cnt_d = cnt_q;
      endcase
      if (push) begin
        wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
      end
    end
  end

  // Response is registered; data and ID hold their last value between pulses.
  always_comb begin
    r_valid_d = 1'b0;
    r_data_d  = r_data_q;
    r_id_d    = r_id_q;
    if (!clear_i && pop) begin
      r_valid_d = 1'b1;
      r_data_d  = p_data_i;
      r_id_d    = id_mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_id_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
      r_id_q    <= r_id_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        id_mem_q[i] <= '0;
      end
    end else if (!clear_i && push) begin
      id_mem_q[wr_ptr_q] <= periph_id_i;
    end
  end

  assign periph_r_valid_o = r_valid_q;
  assign periph_r_data_o  = r_data_q;
  assign periph_r_id_o    = r_id_q;

endmodule

// File: tb/tb_hwpe_ctrl_periph2reqrsp.sv
// Directed bench for hwpe_ctrl_periph2reqrsp: a queue-based model is checked every
// cycle, and literal expectations pin the key scenarios.
module tb_hwpe_ctrl_periph2reqrsp;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned IDW  = 4;
  localparam int unsigned MAXO = 2;

  logic           clk, rst, clear;
  logic           req, gnt, wen, r_valid, q_write, q_valid, q_ready, p_valid, p_ready, busy;
  logic [AW-1:0]  add, q_addr;
  logic [DW/8-1:0] be, q_strb;
  logic [DW-1:0]  data, r_data, q_data, p_data;
  logic [IDW-1:0] id, r_id;

  hwpe_ctrl_periph2reqrsp #(
    .AW(AW), .DW(DW), .ID_WIDTH(IDW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .periph_req_i(req), .periph_gnt_o(gnt), .periph_add_i(add), .periph_wen_i(wen),
    .periph_be_i(be), .periph_data_i(data), .periph_id_i(id),
    .periph_r_data_o(r_data), .periph_r_valid_o(r_valid), .periph_r_id_o(r_id),
    .q_addr_o(q_addr), .q_write_o(q_write), .q_strb_o(q_strb), .q_data_o(q_data),
    .q_valid_o(q_valid), .q_ready_i(q_ready),
    .p_data_i(p_data), .p_valid_i(p_valid), .p_ready_o(p_ready), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: queue of outstanding IDs plus the expected registered response.
  logic [IDW-1:0] idq[$];
  logic           e_rv;
  logic [DW-1:0]  e_rd;
  logic [IDW-1:0] e_rid;
  logic           m_qv, m_gnt;

  int nid;
  int rt[$];
  logic [IDW-1:0] got[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sample at the falling edge and compare everything against the model.
  task automatic chk();
    @(negedge clk);
    if (rst) begin
      idq.delete();
      e_rv  = 1'b0;
      e_rd  = '0;
      e_rid = '0;
    end
    m_qv  = req && (idq.size() < MAXO);
    m_gnt = m_qv && q_ready;
    check("q_valid", 32'(q_valid), 32'(m_qv));
    check("gnt", 32'(gnt), 32'(m_gnt));
    check("p_ready", 32'(p_ready), 32'(idq.size() != 0));
    check("busy", 32'(busy), 32'(idq.size() != 0));
    check("q_addr", q_addr, add);
    check("q_strb", 32'(q_strb), 32'(be));
    check("q_data", q_data, data);
    check("q_write", 32'(q_write), 32'(!wen));
    check("r_valid", 32'(r_valid), 32'(e_rv));
    check("r_data", r_data, e_rd);
    check("r_id", 32'(r_id), 32'(e_rid));
  endtask

  // Advance the model to the state after the coming rising edge, then step past it.
  task automatic adv();
    if (!rst) begin
      if (clear) begin
        idq.delete();
        e_rv = 1'b0;
      end else begin
        e_rv = p_valid && (idq.size() != 0);
        if (e_rv) begin
          e_rd  = p_data;
          e_rid = idq.pop_front();
        end
        if (m_gnt) idq.push_back(id);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    chk();
    adv();
  endtask

  task automatic issue(input logic [IDW-1:0] tid, input logic [AW-1:0] a, input logic w);
    req = 1'b1; id = tid; add = a; wen = w; q_ready = 1'b1;
    data = {a[15:0], 16'h5a5a};
    be = w ? 4'hf : 4'h3;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; clear = 1'b0; req = 1'b0; add = '0; wen = 1'b0; be = '0; data = '0;
    id = '0; q_ready = 1'b0; p_data = '0; p_valid = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();

    // Single read round trip
    issue(4'd1, 32'h100, 1'b1);
    chk();
    check("lit_read_gnt", 32'(gnt), 32'd1);
    check("lit_read_qwrite", 32'(q_write), 32'd0);
    adv();
    req = 1'b0; p_valid = 1'b1; p_data = 32'hDEADBEEF;
    cyc();
    p_valid = 1'b0;
    chk();
    check("lit_read_rvalid", 32'(r_valid), 32'd1);
    check("lit_read_rdata", r_data, 32'hDEADBEEF);
    check("lit_read_rid", 32'(r_id), 32'd1);
    adv();
    cyc();

    // Full stall: two grants, third blocked, even during a pop
    issue(4'd0, 32'h200, 1'b0); cyc();
    issue(4'd1, 32'h204, 1'b0); cyc();
    issue(4'd2, 32'h208, 1'b0);
    chk();
    check("lit_full_qvalid", 32'(q_valid), 32'd0);
    check("lit_full_gnt", 32'(gnt), 32'd0);
    check("lit_full_busy", 32'(busy), 32'd1);
    adv();
    p_valid = 1'b1; p_data = 32'h11;
    chk();
    check("lit_full_pop_gnt", 32'(gnt), 32'd0);
    adv();
    p_valid = 1'b0;
    chk();
    check("lit_full_rid", 32'(r_id), 32'd0);
    check("lit_full_resume_gnt", 32'(gnt), 32'd1);
    adv();
    req = 1'b0; p_valid = 1'b1; p_data = 32'h22; cyc();
    p_data = 32'h33; cyc();
    p_valid = 1'b0; cyc();
    check("lit_drain_rid", 32'(r_id), 32'd2);

    // Ordering and FIFO wrap: six writes, each answered two cycles after its grant
    nid = 0;
    for (int t = 0; t < 20; t++) begin
      if (nid < 6) issue(IDW'(nid), 32'h300 + 32'(t), 1'b0);
      else req = 1'b0;
      p_valid = (rt.size() != 0) && (rt[0] == t);
      p_data  = 32'hA0 + 32'(t);
      chk();
      if (r_valid) got.push_back(r_id);
      if (m_gnt) begin
        rt.push_back(t + 2);
        nid++;
      end
      if (p_valid) void'(rt.pop_front());
      adv();
    end
    p_valid = 1'b0;
    check("lit_order_count", 32'(got.size()), 32'd6);
    for (int i = 0; i < got.size(); i++) check("lit_order_id", 32'(got[i]), 32'(i));

    // Simultaneous grant and response with one outstanding
    issue(4'd3, 32'h400, 1'b1); cyc();
    issue(4'd4, 32'h404, 1'b1); p_valid = 1'b1; p_data = 32'h55;
    chk();
    check("lit_sim_gnt", 32'(gnt), 32'd1);
    check("lit_sim_pready", 32'(p_ready), 32'd1);
    adv();
    req = 1'b0; p_valid = 1'b0;
    chk();
    check("lit_sim_rvalid", 32'(r_valid), 32'd1);
    check("lit_sim_rid", 32'(r_id), 32'd3);
    check("lit_sim_busy", 32'(busy), 32'd1);
    adv();
    p_valid = 1'b1; p_data = 32'h66; cyc();
    p_valid = 1'b0; cyc();

    // Backpressure on the request side
    issue(4'd5, 32'h500, 1'b0); q_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk();
      check("lit_bp_gnt", 32'(gnt), 32'd0);
      adv();
    end
    q_ready = 1'b1;
    chk();
    check("lit_bp_release_gnt", 32'(gnt), 32'd1);
    adv();
    req = 1'b0; p_valid = 1'b1; p_data = 32'h77; cyc();
    p_valid = 1'b0; cyc();
    check("lit_bp_rid", 32'(r_id), 32'd5);
    cyc();

    // Synchronous clear with two outstanding overrides a concurrent response
    issue(4'd1, 32'h600, 1'b0); cyc();
    issue(4'd2, 32'h604, 1'b0); cyc();
    req = 1'b0; clear = 1'b1; p_valid = 1'b1; p_data = 32'h88; cyc();
    clear = 1'b0; p_valid = 1'b0;
    chk();
    check("lit_clr_busy", 32'(busy), 32'd0);
    check("lit_clr_pready", 32'(p_ready), 32'd0);
    check("lit_clr_rvalid", 32'(r_valid), 32'd0);
    adv();
    p_valid = 1'b1; p_data = 32'h99; cyc();
    p_valid = 1'b0;
    issue(4'd6, 32'h608, 1'b1); cyc();
    req = 1'b0; p_valid = 1'b1; p_data = 32'h1234; cyc();
    p_valid = 1'b0; cyc();
    check("lit_clr_after_rid", 32'(r_id), 32'd6);

    // Asynchronous reset between clock edges with two outstanding
    issue(4'd8, 32'h700, 1'b0); cyc();
    issue(4'd9, 32'h704, 1'b0); cyc();
    req = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("lit_rst_busy", 32'(busy), 32'd0);
    check("lit_rst_pready", 32'(p_ready), 32'd0);
    check("lit_rst_rvalid", 32'(r_valid), 32'd0);
    check("lit_rst_rdata", r_data, 32'd0);
    check("lit_rst_rid", 32'(r_id), 32'd0);
    cyc();
    rst = 1'b0;
    p_valid = 1'b1; p_data = 32'hBAD; cyc();
    p_valid = 1'b0; cyc();
    issue(4'd10, 32'h800, 1'b1); cyc();
    req = 1'b0; p_valid = 1'b1; p_data = 32'hCAFE; cyc();
    p_valid = 1'b0; cyc();
    check("lit_rst_after_rdata", r_data, 32'hCAFE);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
